// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants and state type for the SHA-256 front end
package sha256_pkg;

  localparam int SHA_BLK_W  = 512;
  localparam int SHA_LEN_W  = 64;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int LEN_OFFSET = 56;

  typedef enum logic [1:0] {
    S_COLLECT,
    S_PAD,
    S_OUT,
    S_EXTRA
  } pad_state_t;

endpackage

// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - byte-stream to padded 512-bit block converter for SHA-256
//   clk, reset                              : clock, async active-high reset
//   in_data/in_valid/in_last/in_ready       : message byte stream
//   block/block_valid/block_ready           : padded block stream, byte i at [8i:8i+7]
//   block_first/block_last                  : message boundaries, qualified by block_valid
//   busy                                    : message in progress
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = SHA_LEN_W,
  parameter int BLK_W = SHA_BLK_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [0:BLK_W-1] block,
  output logic             block_valid,
  input  logic             block_ready,
  output logic             block_first,
  output logic             block_last,
  output logic             busy
);

  localparam int NBYTES = BLK_W / 8;

  pad_state_t       state, state_n;
  logic [0:BLK_W-1] blk_q;
  logic [5:0]       idx;
  logic [6:0]       p;
  logic [LEN_W-1:0] len;
  logic [63:0]      len64;
  logic             fin, need_extra, first_flag, busy_q;
  logic             in_xfer, blk_xfer;

  assign len64    = 64'(len);
  assign in_xfer  = in_valid & in_ready;
  assign blk_xfer = block_valid & block_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_COLLECT;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    in_ready    = 1'b0;
    block_valid = 1'b0;
    block_first = 1'b0;
    block_last  = 1'b0;
    case (state)
      S_COLLECT: begin
        // Gated by reset so in_ready reads 0 while reset is held.
        in_ready = !reset;
        if (in_xfer) begin
          if (in_last)         state_n = S_PAD;
          else if (idx == 6'd63) state_n = S_OUT;
        end
      end
      S_PAD:   state_n = S_OUT;
      S_OUT: begin
        block_valid = 1'b1;
        block_first = first_flag;
        block_last  = fin;
        if (blk_xfer) state_n = need_extra ? S_EXTRA : S_COLLECT;
      end
      S_EXTRA: state_n = S_OUT;
      default: state_n = S_COLLECT;
    endcase
  end

  // Control state: byte index, pad position, bit length, block flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      p          <= '0;
      len        <= '0;
      fin        <= 1'b0;
      need_extra <= 1'b0;
      first_flag <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_xfer) begin
            idx    <= idx + 6'd1;
            len    <= len + LEN_W'(8);
            busy_q <= 1'b1;
            if (in_last) begin
              p <= {1'b0, idx} + 7'd1;
            end else if (idx == 6'd63) begin
              fin        <= 1'b0;
              need_extra <= 1'b0;
            end
          end
        end
        S_PAD: begin
          // Length fits behind the pad byte only if the message ends by byte 55.
          if (p <= 7'(LEN_OFFSET - 1)) begin
            fin        <= 1'b1;
            need_extra <= 1'b0;
          end else begin
            fin        <= 1'b0;
            need_extra <= 1'b1;
          end
        end
        S_OUT: begin
          if (blk_xfer) begin
            first_flag <= 1'b0;
            idx        <= '0;
            if (fin) begin
              len        <= '0;
              first_flag <= 1'b1;
              busy_q     <= 1'b0;
            end
          end
        end
        S_EXTRA: begin
          fin        <= 1'b1;
          need_extra <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Byte-lane writes into the block buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_q <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (in_xfer) blk_q[8*idx +: 8] <= in_data;
        end
        S_PAD: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (7'(i) == p)     blk_q[8*i +: 8] <= PAD_BYTE;
            else if (7'(i) > p) blk_q[8*i +: 8] <= 8'h00;
            if (p <= 7'(LEN_OFFSET - 1) && i >= LEN_OFFSET)
              blk_q[8*i +: 8] <= len64[8*(NBYTES-1-i) +: 8];
          end
        end
        S_EXTRA: begin
          // The pad byte lands here only when the message filled the previous block exactly.
          for (int i = 0; i < NBYTES; i++) begin
            if (i >= LEN_OFFSET)
              blk_q[8*i +: 8] <= len64[8*(NBYTES-1-i) +: 8];
            else if (i == 0 && p == 7'd64)
              blk_q[8*i +: 8] <= PAD_BYTE;
            else
              blk_q[8*i +: 8] <= 8'h00;
          end
        end
        default: ;
      endcase
    end
  end

  assign block = blk_q;
  assign busy  = busy_q;

endmodule
